// File: rtl/servo_pwm_pkg.sv
// Shared Q16.16 helpers for the servo PWM bank.
// Angle clamp, per-frame slew step and pulse-width scaling.
package servo_pwm_pkg;

    localparam int Q_FRAC = 16;

    typedef logic signed [31:0] q16_t;

    function automatic q16_t q_clamp(q16_t a, int unsigned max_deg);
        q16_t hi;
        hi = q16_t'(max_deg << Q_FRAC);
        if (a < 0) return '0;
        if (a > hi) return hi;
        return a;
    endfunction

    function automatic q16_t q_step(q16_t cur, q16_t tgt, q16_t step);
        q16_t d;
        q16_t ad;
        d  = tgt - cur;
        ad = d[31] ? -d : d;
        if (step == 0 || ad <= step) return tgt;
        return d[31] ? cur - step : cur + step;
    endfunction

    // Ceiling keeps ANG_MAX landing on the full span despite truncation.
    function automatic logic [31:0] q_scale(int unsigned span,
                                            int unsigned ang_max);
        logic [63:0] num;
        num = (64'(span) << Q_FRAC) + 64'(ang_max) - 64'd1;
        return 32'(num / 64'(ang_max));
    endfunction

    function automatic logic [31:0] q_width(q16_t cur, logic [31:0] scale);
        return 32'((64'($unsigned(cur)) * 64'(scale)) >> (2 * Q_FRAC));
    endfunction

endpackage

// File: rtl/servo_pwm_bank_if.sv
// Target-angle write port: valid/ready with channel index and angle.
interface servo_pwm_bank_if
    import servo_pwm_pkg::*;
#(
    parameter int CH_W = 2
);

    logic            tgt_valid;
    logic            tgt_ready;
    logic [CH_W-1:0] tgt_ch;
    q16_t            tgt_angle;

    modport master (
        output tgt_valid,
        output tgt_ch,
        output tgt_angle,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_ch,
        input  tgt_angle,
        output tgt_ready
    );

endinterface

// File: rtl/servo_slew_channel.sv
// One servo channel: target/current angle, slew, width latch, pulse.
module servo_slew_channel
    import servo_pwm_pkg::*;
#(
    parameter int          CNT_W   = 8,
    parameter int          MIN_CYC = 50,
    parameter int          ANG_MAX = 180,
    parameter logic [31:0] SCALE   = 32'd36409,
    parameter q16_t        STEP_Q  = 32'h0002_0000,
    parameter q16_t        HOME_Q  = 32'h005A_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  q16_t             wr_angle,
    input  logic             step_en,
    input  logic             frame_start,
    input  logic [CNT_W-1:0] frame_cnt,
    input  logic             en,
    output logic             pwm,
    output logic             settled,
    output logic             clip
);

    localparam logic [CNT_W-1:0] HOME_W =
        CNT_W'(32'(MIN_CYC) + q_width(HOME_Q, SCALE));

    q16_t             tgt;
    q16_t             cur;
    q16_t             wr_clamped;
    logic [CNT_W-1:0] width;
    logic             arm;
    logic             gate;

    assign wr_clamped = q_clamp(wr_angle, ANG_MAX);

    // Enable must be high from the frame start on, so a late enable
    // never produces a runt pulse.
    assign gate = en && (frame_start || arm);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt     <= HOME_Q;
            cur     <= HOME_Q;
            width   <= HOME_W;
            clip    <= 1'b0;
            settled <= 1'b1;
            arm     <= 1'b0;
            pwm     <= 1'b0;
        end else begin
            if (wr) begin
                tgt  <= wr_clamped;
                clip <= (wr_clamped != wr_angle);
            end
            if (step_en)
                cur <= q_step(cur, tgt, STEP_Q);
            if (frame_start)
                width <= CNT_W'(32'(MIN_CYC) + q_width(cur, SCALE));
            settled <= (cur == tgt);
            arm     <= gate;
            pwm     <= gate && (frame_cnt < width);
        end
    end

endmodule

// File: rtl/servo_pwm_bank.sv
// N-channel hobby-servo PWM bank with clamped, slew-limited targets.
module servo_pwm_bank
    import servo_pwm_pkg::*;
#(
    parameter int   N_CH     = 3,
    parameter int   CLK_HZ   = 50_000_000,
    parameter int   FRAME_US = 20000,
    parameter int   MIN_US   = 500,
    parameter int   MAX_US   = 2500,
    parameter int   ANG_MAX  = 180,
    parameter q16_t STEP_Q   = 32'h0002_0000,
    parameter q16_t HOME_Q   = 32'h005A_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    servo_pwm_bank_if.slave  tgt,
    input  logic [N_CH-1:0]  en,
    output logic [N_CH-1:0]  pwm,
    output logic             frame_tick,
    output logic [N_CH-1:0]  settled,
    output logic [N_CH-1:0]  clip
);

    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CYC_US    = CLK_HZ / 1_000_000;
    localparam int FRAME_CYC = CYC_US * FRAME_US;
    localparam int MIN_CYC   = CYC_US * MIN_US;
    localparam int MAX_CYC   = CYC_US * MAX_US;
    localparam int SPAN      = MAX_CYC - MIN_CYC;
    localparam int CNT_W     = $clog2(FRAME_CYC + 1);

    localparam logic [31:0]      SCALE = q_scale(SPAN, ANG_MAX);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_CYC - 1);

    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ready;
    logic             fire;
    logic             step_en;
    logic             frame_start;

    assign cnt_nxt     = (frame_cnt == LAST) ? '0 : frame_cnt + CNT_W'(1);
    assign step_en     = (frame_cnt == LAST);
    assign frame_start = (frame_cnt == '0);
    assign fire        = tgt.tgt_valid && ready;
    assign tgt.tgt_ready = ready;

    // Ready drops for the last frame cycle so writes never race the step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
            ready      <= 1'b0;
        end else begin
            frame_cnt  <= cnt_nxt;
            frame_tick <= frame_start;
            ready      <= (cnt_nxt != LAST);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr;

        assign wr = fire && (tgt.tgt_ch == CH_W'(i));

        servo_slew_channel #(
            .CNT_W   (CNT_W),
            .MIN_CYC (MIN_CYC),
            .ANG_MAX (ANG_MAX),
            .SCALE   (SCALE),
            .STEP_Q  (STEP_Q),
            .HOME_Q  (HOME_Q)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr          (wr),
            .wr_angle    (tgt.tgt_angle),
            .step_en     (step_en),
            .frame_start (frame_start),
            .frame_cnt   (frame_cnt),
            .en          (en[i]),
            .pwm         (pwm[i]),
            .settled     (settled[i]),
            .clip        (clip[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench: dut0 jumps (no slew), dut1 slews 10 deg per frame.
module tb_servo_pwm_bank;
    import servo_pwm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] en = 3'b111;
    logic [2:0] pwm_a [2];
    logic [2:0] settled_a [2];
    logic [2:0] clip_a [2];
    logic       tick_a [2];

    int n_cmp = 0;
    int n_bad = 0;
    int hi [2][3];
    logic [2:0] st0 [2];

    servo_pwm_bank_if #(.CH_W(2)) tif0 ();
    servo_pwm_bank_if #(.CH_W(2)) tif1 ();

    always #5 clk = ~clk;

    servo_pwm_bank #(
        .N_CH(3), .CLK_HZ(1_000_000), .FRAME_US(200),
        .MIN_US(50), .MAX_US(150), .ANG_MAX(180),
        .STEP_Q(32'h0000_0000), .HOME_Q(32'h005A_0000)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .tgt(tif0.slave), .en(en),
        .pwm(pwm_a[0]), .frame_tick(tick_a[0]),
        .settled(settled_a[0]), .clip(clip_a[0])
    );

    servo_pwm_bank #(
        .N_CH(3), .CLK_HZ(1_000_000), .FRAME_US(200),
        .MIN_US(50), .MAX_US(150), .ANG_MAX(180),
        .STEP_Q(32'h000A_0000), .HOME_Q(32'h005A_0000)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .tgt(tif1.slave), .en(en),
        .pwm(pwm_a[1]), .frame_tick(tick_a[1]),
        .settled(settled_a[1]), .clip(clip_a[1])
    );

    task automatic drive(int d, logic v, logic [1:0] ch, q16_t a);
        if (d == 0) begin
            tif0.tgt_valid = v; tif0.tgt_ch = ch; tif0.tgt_angle = a;
        end else begin
            tif1.tgt_valid = v; tif1.tgt_ch = ch; tif1.tgt_angle = a;
        end
    endtask

    function automatic logic rdy(int d);
        return (d == 0) ? tif0.tgt_ready : tif1.tgt_ready;
    endfunction

    task automatic write(int d, logic [1:0] ch, q16_t a);
        int n;
        n = 0;
        @(negedge clk);
        drive(d, 1'b1, ch, a);
        while (rdy(d) !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 10) begin
            n_bad++;
            $display("FAIL write_timeout dut%0d: ready=0 required 1", d);
        end
        @(negedge clk);
        drive(d, 1'b0, 2'd0, '0);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (tick_a[0] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 400) begin
            n_bad++;
            $display("FAIL tick_timeout: no frame_tick, required one");
        end
    endtask

    // Counts one frame of pwm, starting at a frame_tick sample and
    // ending on the next frame's frame_tick sample.
    task automatic measure();
        int t;
        t = 0;
        wait_tick();
        for (int d = 0; d < 2; d++) begin
            st0[d] = settled_a[d];
            for (int c = 0; c < 3; c++) hi[d][c] = 0;
        end
        for (int i = 0; i < 200; i++) begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 3; c++)
                    if (pwm_a[d][c] === 1'b1) hi[d][c]++;
            if (tick_a[0] === 1'b1) t++;
            @(negedge clk);
        end
        n_cmp++;
        if (t !== 1) begin
            n_bad++;
            $display("FAIL tick_count: got %0d per frame, required 1", t);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 3'b111;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (pwm_a[d] !== 3'b000 || tick_a[d] !== 1'b0 ||
                settled_a[d] !== 3'b111 || clip_a[d] !== 3'b000 ||
                rdy(d) !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: pwm=%b tick=%b st=%b clip=%b rdy=%b, required 000 0 111 000 0",
                         d, pwm_a[d], tick_a[d], settled_a[d], clip_a[d], rdy(d));
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tick_a[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL first_tick: got %b, required 1", tick_a[0]);
        end
        measure();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (hi[d][c] !== 100) begin
                    n_bad++;
                    $display("FAIL home_width dut%0d ch%0d: got %0d, required 100",
                             d, c, hi[d][c]);
                end
            end
        n_cmp++;
        if (tick_a[0] !== 1'b1 || st0[0] !== 3'b111) begin
            n_bad++;
            $display("FAIL tick_period_settled: tick=%b st=%b, required 1 111",
                     tick_a[0], st0[0]);
        end
    endtask

    task automatic test_jump();
        int e [3];
        e = '{50, 75, 150};
        wait_tick();
        repeat (10) @(negedge clk);
        write(0, 2'd0, 32'h0000_0000);
        write(0, 2'd1, 32'h002D_0000);
        write(0, 2'd2, 32'h00B4_0000);
        measure();
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (hi[0][c] !== e[c] || hi[1][c] !== 100) begin
                n_bad++;
                $display("FAIL jump_width ch%0d: got %0d/%0d, required %0d/100",
                         c, hi[0][c], hi[1][c], e[c]);
            end
        end
        n_cmp++;
        if (clip_a[0] !== 3'b000 || st0[0] !== 3'b111) begin
            n_bad++;
            $display("FAIL jump_flags: clip=%b st=%b, required 000 111",
                     clip_a[0], st0[0]);
        end
    endtask

    task automatic test_slew();
        int e [3];
        logic s [3];
        e = '{105, 111, 116};
        s = '{1'b0, 1'b0, 1'b1};
        wait_tick();
        repeat (10) @(negedge clk);
        write(1, 2'd0, 32'h0078_0000);
        @(negedge clk);
        n_cmp++;
        if (settled_a[1][0] !== 1'b0) begin
            n_bad++;
            $display("FAIL slew_unsettled: got %b, required 0",
                     settled_a[1][0]);
        end
        for (int f = 0; f < 3; f++) begin
            measure();
            n_cmp++;
            if (hi[1][0] !== e[f] || st0[1][0] !== s[f]) begin
                n_bad++;
                $display("FAIL slew_frame%0d: width=%0d st=%b, required %0d %b",
                         f, hi[1][0], st0[1][0], e[f], s[f]);
            end
        end
        n_cmp++;
        if (hi[1][1] !== 100 || hi[1][2] !== 100) begin
            n_bad++;
            $display("FAIL slew_others: got %0d/%0d, required 100/100",
                     hi[1][1], hi[1][2]);
        end
    endtask

    task automatic test_clip();
        wait_tick();
        repeat (10) @(negedge clk);
        write(0, 2'd1, 32'hFFFB_0000);
        write(0, 2'd2, 32'h00C8_0000);
        measure();
        n_cmp++;
        if (hi[0][1] !== 50 || hi[0][2] !== 150 || clip_a[0] !== 3'b110) begin
            n_bad++;
            $display("FAIL clip_set: w1=%0d w2=%0d clip=%b, required 50 150 110",
                     hi[0][1], hi[0][2], clip_a[0]);
        end
        write(0, 2'd1, 32'h000A_0000);
        @(negedge clk);
        n_cmp++;
        if (clip_a[0] !== 3'b100) begin
            n_bad++;
            $display("FAIL clip_clear: got %b, required 100", clip_a[0]);
        end
        measure();
        n_cmp++;
        if (hi[0][1] !== 55) begin
            n_bad++;
            $display("FAIL clip_10deg: got %0d, required 55", hi[0][1]);
        end
    endtask

    task automatic test_handshake();
        wait_tick();
        repeat (198) @(negedge clk);
        drive(0, 1'b1, 2'd0, 32'h001E_0000);
        n_cmp++;
        if (rdy(0) !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_last: got %b, required 0", rdy(0));
        end
        @(negedge clk);
        n_cmp++;
        if (rdy(0) !== 1'b1 || tick_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_cnt0: rdy=%b tick=%b, required 1 0",
                     rdy(0), tick_a[0]);
        end
        @(negedge clk);
        drive(0, 1'b0, 2'd0, '0);
        measure();
        n_cmp++;
        if (hi[0][0] !== 50) begin
            n_bad++;
            $display("FAIL hs_same_frame: got %0d, required 50", hi[0][0]);
        end
        measure();
        n_cmp++;
        if (hi[0][0] !== 66) begin
            n_bad++;
            $display("FAIL hs_next_frame: got %0d, required 66", hi[0][0]);
        end
        write(0, 2'd3, 32'hFFFF_0000);
        measure();
        n_cmp++;
        if (hi[0][0] !== 66 || hi[0][1] !== 55 || hi[0][2] !== 150 ||
            clip_a[0] !== 3'b100) begin
            n_bad++;
            $display("FAIL bad_channel: w=%0d/%0d/%0d clip=%b, required 66/55/150 100",
                     hi[0][0], hi[0][1], hi[0][2], clip_a[0]);
        end
    endtask

    task automatic test_enable();
        wait_tick();
        repeat (10) @(negedge clk);
        n_cmp++;
        if (pwm_a[0][0] !== 1'b1) begin
            n_bad++;
            $display("FAIL en_pre: got %b, required 1", pwm_a[0][0]);
        end
        en = 3'b110;
        @(negedge clk);
        n_cmp++;
        if (pwm_a[0][0] !== 1'b0 || pwm_a[0][1] !== 1'b1 ||
            pwm_a[1][0] !== 1'b0) begin
            n_bad++;
            $display("FAIL en_drop: got %b %b %b, required 0 1 0",
                     pwm_a[0][0], pwm_a[0][1], pwm_a[1][0]);
        end
        repeat (10) @(negedge clk);
        en = 3'b111;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pwm_a[0][0] !== 1'b0 || pwm_a[1][0] !== 1'b0) begin
            n_bad++;
            $display("FAIL en_late: got %b %b, required 0 0",
                     pwm_a[0][0], pwm_a[1][0]);
        end
        measure();
        n_cmp++;
        if (hi[0][0] !== 66 || hi[1][0] !== 116) begin
            n_bad++;
            $display("FAIL en_resume: got %0d/%0d, required 66/116",
                     hi[0][0], hi[1][0]);
        end
    endtask

    task automatic test_reset_mid();
        wait_tick();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (pwm_a[0] !== 3'b111) begin
            n_bad++;
            $display("FAIL mid_pre: got %b, required 111", pwm_a[0]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (pwm_a[d] !== 3'b000 || tick_a[d] !== 1'b0 ||
                settled_a[d] !== 3'b111 || clip_a[d] !== 3'b000 ||
                rdy(d) !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_reset dut%0d: pwm=%b tick=%b st=%b clip=%b rdy=%b, required 000 0 111 000 0",
                         d, pwm_a[d], tick_a[d], settled_a[d], clip_a[d], rdy(d));
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        measure();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (hi[d][0] !== 100 || hi[d][1] !== 100 || hi[d][2] !== 100) begin
                n_bad++;
                $display("FAIL mid_home dut%0d: got %0d/%0d/%0d, required 100",
                         d, hi[d][0], hi[d][1], hi[d][2]);
            end
        end
    endtask

    initial begin
        drive(0, 1'b0, 2'd0, '0);
        drive(1, 1'b0, 2'd0, '0);
        test_reset();
        test_jump();
        test_slew();
        test_clip();
        test_handshake();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
